// File: rtl/pipe_issue_arbiter_if.sv
// Issue/result bundle between the requester lanes, the shared unit and pipe_issue_arbiter.
interface pipe_issue_arbiter_if #(
    parameter int element_width = 64,
    parameter int NUM_REQ       = 4,
    parameter int LATENCY       = 4,
    parameter int ID_W          = $clog2(NUM_REQ),
    parameter int IF_W          = $clog2(LATENCY + 2)
);
    logic [NUM_REQ-1:0]               req;
    logic [NUM_REQ*element_width-1:0] req_data;
    logic                             hold;
    logic [NUM_REQ-1:0]               gnt;
    logic [element_width-1:0]         unit_in;
    logic                             unit_in_valid;
    logic [element_width-1:0]         unit_out;
    logic [NUM_REQ-1:0]               res_valid;
    logic [ID_W-1:0]                  res_id;
    logic [element_width-1:0]         res_data;
    logic [IF_W-1:0]                  inflight;
    logic                             idle;

    modport master (
        output req, req_data, hold, unit_out,
        input  gnt, unit_in, unit_in_valid, res_valid, res_id, res_data, inflight, idle
    );

    modport slave (
        input  req, req_data, hold, unit_out,
        output gnt, unit_in, unit_in_valid, res_valid, res_id, res_data, inflight, idle
    );
endinterface

// File: rtl/pipe_issue_arbiter.sv
// Round-robin issue into a shared non-stallable LATENCY-deep unit, with a tag pipe steering results back.
// Latency: gnt combinational; unit_in one cycle after grant; result strobe LATENCY+1 cycles after grant.
// Backpressure: only hold (drain); the unit never stalls, so tags shift unconditionally.
module pipe_issue_arbiter #(
    parameter int element_width = 64,
    parameter int NUM_REQ       = 4,
    parameter int LATENCY       = 4,
    parameter int ID_W          = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    pipe_issue_arbiter_if.slave  bus
);
    localparam int IF_W = $clog2(LATENCY + 2);

    logic [ID_W-1:0]          r_ptr;
    logic [element_width-1:0] r_unit_in;
    logic [LATENCY:0]         r_tag_vld;
    logic [ID_W-1:0]          r_tag_id [0:LATENCY];
    logic [IF_W-1:0]          r_inflight;

    logic                     w_gnt_vld;
    logic [ID_W-1:0]          w_gnt_id;
    logic [ID_W-1:0]          w_ptr_nxt;
    logic [NUM_REQ-1:0]       w_gnt;

    // First requester at or above the pointer, wrapping; nothing while in reset or on hold.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_id  = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            int idx;
            idx = (int'(r_ptr) + off) % NUM_REQ;
            if (!rst && !bus.hold && !w_gnt_vld && bus.req[idx[ID_W-1:0]]) begin
                w_gnt_vld = 1'b1;
                w_gnt_id  = idx[ID_W-1:0];
            end
        end
    end

    assign w_gnt     = {{(NUM_REQ-1){1'b0}}, w_gnt_vld} << w_gnt_id;
    assign w_ptr_nxt = (w_gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_id + ID_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr      <= '0;
            r_unit_in  <= '0;
            r_tag_vld  <= '0;
            r_inflight <= '0;
            for (int k = 0; k <= LATENCY; k++) begin
                r_tag_id[k] <= '0;
            end
        end else begin
            if (w_gnt_vld) begin
                r_ptr       <= w_ptr_nxt;
                r_unit_in   <= bus.req_data[int'(w_gnt_id)*element_width +: element_width];
                r_tag_id[0] <= w_gnt_id;
            end
            // Stage 0 is the issue register; stages 1..LATENCY track the unit's own registers.
            r_tag_vld <= {r_tag_vld[LATENCY-1:0], w_gnt_vld};
            for (int k = 1; k <= LATENCY; k++) begin
                r_tag_id[k] <= r_tag_id[k-1];
            end
            case ({w_gnt_vld, r_tag_vld[LATENCY]})
                2'b10:   r_inflight <= r_inflight + IF_W'(1);
                2'b01:   r_inflight <= r_inflight - IF_W'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    assign bus.gnt           = w_gnt;
    assign bus.unit_in       = r_unit_in;
    assign bus.unit_in_valid = r_tag_vld[0];
    assign bus.res_valid     = {{(NUM_REQ-1){1'b0}}, r_tag_vld[LATENCY]} << r_tag_id[LATENCY];
    assign bus.res_id        = r_tag_id[LATENCY];
    assign bus.res_data      = bus.unit_out;
    assign bus.inflight      = r_inflight;
    assign bus.idle          = (r_inflight == '0) && (bus.req == '0);
endmodule

// File: tb/tb_pipe_issue_arbiter.sv
// Directed stimulus with a per-cycle reference model and a result scoreboard for pipe_issue_arbiter.
module tb_pipe_issue_arbiter;
    localparam int W   = 64;
    localparam int NR  = 4;
    localparam int LAT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_issue_arbiter_if #(.element_width(W), .NUM_REQ(NR), .LATENCY(LAT)) bus ();

    pipe_issue_arbiter #(.element_width(W), .NUM_REQ(NR), .LATENCY(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Shared unit stand-in: plain LAT-register delay line with no reset.
    logic [W-1:0] u_p [0:LAT-1];
    always @(posedge clk) begin
        u_p[0] <= bus.unit_in;
        for (int k = 1; k < LAT; k++) u_p[k] <= u_p[k-1];
    end
    assign bus.unit_out = u_p[LAT-1];

    typedef struct {
        int           id;
        logic [W-1:0] dat;
        int           due;
    } exp_t;

    exp_t          sb [$];
    int            n_chk  = 0;
    int            n_pass = 0;
    int            cyc    = 0;
    int            m_ptr  = 0;
    int            m_infl = 0;
    logic          m_prev_vld = 1'b0;
    logic [W-1:0]  m_prev_dat = '0;
    logic [NR-1:0] m_last_gnt = '0;
    logic          refill = 1'b0;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    function automatic logic [W-1:0] lane_dat(input int lane);
        return {lane[7:0], 24'h0, $urandom()};
    endfunction

    // Reference model, evaluated mid-cycle.
    always @(negedge clk) begin
        logic [NR-1:0] eg;
        int            eid;
        logic          found;
        logic          ret;
        exp_t          e;
        eg = '0; eid = 0; found = 1'b0; ret = 1'b0;
        if (rst) begin
            sb.delete();
            m_ptr = 0; m_infl = 0; m_prev_vld = 1'b0; m_last_gnt = '0;
            chk("rst_gnt", W'(bus.gnt), '0);
            chk("rst_res_valid", W'(bus.res_valid), '0);
            chk("rst_res_id", W'(bus.res_id), '0);
            chk("rst_unit_in_valid", W'(bus.unit_in_valid), '0);
            chk("rst_inflight", W'(bus.inflight), '0);
            chk("rst_idle", W'(bus.idle), W'(bus.req == '0));
        end else begin
            if (!bus.hold) begin
                for (int off = 0; off < NR; off++) begin
                    int idx;
                    idx = (m_ptr + off) % NR;
                    if (!found && bus.req[idx]) begin
                        found = 1'b1;
                        eid   = idx;
                    end
                end
            end
            if (found) eg[eid] = 1'b1;
            chk("gnt", W'(bus.gnt), W'(eg));
            chk("unit_in_valid", W'(bus.unit_in_valid), W'(m_prev_vld));
            if (m_prev_vld) chk("unit_in", bus.unit_in, m_prev_dat);
            chk("inflight", W'(bus.inflight), W'(m_infl));
            chk("idle", W'(bus.idle), W'((m_infl == 0) && (bus.req == '0)));
            if (sb.size() > 0 && sb[0].due == cyc) begin
                ret = 1'b1;
                e   = sb.pop_front();
                chk("res_valid", W'(bus.res_valid), W'(1) << e.id);
                chk("res_id", W'(bus.res_id), W'(e.id));
                chk("res_data", bus.res_data, e.dat);
            end else begin
                chk("res_valid_idle", W'(bus.res_valid), '0);
            end
            if (found) begin
                e.id  = eid;
                e.dat = bus.req_data[eid*W +: W];
                e.due = cyc + LAT + 1;
                sb.push_back(e);
                m_ptr      = (eid + 1) % NR;
                m_prev_dat = e.dat;
            end
            m_infl     = m_infl + int'(found) - int'(ret);
            m_prev_vld = found;
            m_last_gnt = eg;
        end
        cyc++;
    end

    // One clock: granted lanes drop their request, or re-request with new data when refilling.
    task automatic step();
        logic [NR-1:0] g;
        @(posedge clk);
        #1;
        g = m_last_gnt;
        bus.req = bus.req & ~g;
        if (refill) begin
            for (int i = 0; i < NR; i++) begin
                if (g[i]) begin
                    bus.req[i] = 1'b1;
                    bus.req_data[i*W +: W] = lane_dat(i);
                end
            end
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        bus.req      = '0;
        bus.req_data = '0;
        bus.hold     = 1'b0;
        #1;
        chk("reset_idle", W'(bus.idle), W'(1));
        chk("reset_unit_in", bus.unit_in, '0);
        step();
        bus.req = 4'b1111;
        #1;
        chk("gnt_forced_0_in_reset", W'(bus.gnt), '0);
        bus.req = '0;
        step();
        rst = 1'b0;

        // Single op on lane 0.
        bus.req_data[0 +: W] = 64'h1111_2222_3333_4444;
        bus.req = 4'b0001;
        #1;
        chk("single_gnt", W'(bus.gnt), W'(4'b0001));
        step();
        chk("single_uiv", W'(bus.unit_in_valid), W'(1));
        chk("single_inflight", W'(bus.inflight), W'(1));
        steps(4);
        chk("single_res_valid", W'(bus.res_valid), W'(4'b0001));
        chk("single_res_data", bus.res_data, 64'h1111_2222_3333_4444);
        steps(2);
        chk("single_inflight_done", W'(bus.inflight), '0);

        // Fairness and steady stream.
        for (int i = 0; i < NR; i++) bus.req_data[i*W +: W] = lane_dat(i);
        refill  = 1'b1;
        bus.req = 4'b1111;
        steps(10);
        chk("steady_inflight", W'(bus.inflight), W'(LAT + 1));

        // Short hold, then a long one that drains the unit.
        bus.hold = 1'b1;
        steps(3);
        bus.hold = 1'b0;
        steps(6);
        bus.hold = 1'b1;
        steps(7);
        chk("hold_drained", W'(bus.inflight), '0);
        chk("hold_not_idle", W'(bus.idle), '0);
        bus.hold = 1'b0;
        refill   = 1'b0;
        steps(12);
        chk("drained_idle", W'(bus.idle), W'(1));

        // Wrap and skip around the pointer.
        bus.req_data[2*W +: W] = lane_dat(2);
        bus.req = 4'b0100;
        step();
        bus.req_data[0 +: W] = lane_dat(0);
        bus.req_data[W +: W] = lane_dat(1);
        bus.req = 4'b0011;
        #1;
        chk("wrap_gnt0", W'(bus.gnt), W'(4'b0001));
        step();
        chk("wrap_gnt1", W'(bus.gnt), W'(4'b0010));
        step();
        bus.req_data[2*W +: W] = lane_dat(2);
        bus.req_data[3*W +: W] = lane_dat(3);
        bus.req = 4'b1111;
        #1;
        chk("wrap_ptr2", W'(bus.gnt), W'(4'b0100));
        steps(12);

        // Asynchronous reset with three ops in flight.
        refill  = 1'b1;
        bus.req = 4'b1111;
        steps(3);
        refill = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_res_valid", W'(bus.res_valid), '0);
        chk("arst_uiv", W'(bus.unit_in_valid), '0);
        chk("arst_inflight", W'(bus.inflight), '0);
        steps(2);
        rst = 1'b0;
        steps(14);
        chk("final_idle", W'(bus.idle), W'(1));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
